// File: rtl/tx_sched_pkg.sv
// Shared definitions for the transmit scheduler: default data width,
// FSM state encodings and the default watchdog limit.
package tx_sched_pkg;

  localparam int DATA_MSB    = 7;
  localparam int TIMEOUT_DEF = 1023;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/tx_sched_rr_pick.sv
// Combinational round-robin picker: rotate requests so ptr is bit 0,
// take the lowest set bit, then rotate the index back.
module rr_pick #(
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               any,
  output logic [SEL_W-1:0]   sel
);

  logic [NUM_SRC-1:0] w_rot;
  logic [SEL_W-1:0]   w_off;

  always_comb begin
    w_rot = '0;
    w_off = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_rot[i] = req[(i + int'(ptr)) % NUM_SRC];
    end
    // Descending scan so the lowest set bit is the one that sticks.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = SEL_W'(i);
    end
    any = |req;
    sel = SEL_W'((int'(w_off) + int'(ptr)) % NUM_SRC);
  end

endmodule

// File: rtl/tx_sched.sv
// Round-robin scheduler feeding one shared 4-phase transmitter, with a
// sticky stall watchdog and a wrapping sent-word counter.
module tx_sched
  import tx_sched_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = DATA_MSB + 1,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = 16
) (
  input  logic                        clk_tx,
  input  logic                        reset,
  input  logic [NUM_SRC-1:0]          src_valid,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  output logic [NUM_SRC-1:0]          src_done,
  output logic                        vi,
  output logic [DATA_W-1:0]           sdata,
  input  logic                        snt,
  output logic [$clog2(NUM_SRC)-1:0]  grant_id,
  output logic                        busy,
  input  logic                        err_clr,
  output logic                        timeout_err,
  output logic [CNT_W-1:0]            word_cnt
);

  localparam int              SEL_W  = $clog2(NUM_SRC);
  localparam bit              WD_EN  = (TIMEOUT != 0);
  localparam int              WD_W   = WD_EN ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0] WD_PRE = WD_W'(WD_EN ? TIMEOUT - 1 : 0);

  state_t              r_state, w_state_nxt;
  logic [SEL_W-1:0]    r_ptr, r_grant;
  logic [DATA_W-1:0]   r_sdata;
  logic [NUM_SRC-1:0]  r_done;
  logic [CNT_W-1:0]    r_cnt;
  logic [WD_W-1:0]     r_wd;
  logic                r_err;
  logic                w_any, w_fire, w_done, w_wd_set;
  logic [SEL_W-1:0]    w_sel;

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_pick (
    .req (src_valid),
    .ptr (r_ptr),
    .any (w_any),
    .sel (w_sel)
  );

  assign w_fire   = (r_state == IDLE) && w_any;
  assign w_done   = (r_state == BUSY) && snt;
  assign w_wd_set = WD_EN && (r_state == BUSY) && !snt && (r_wd == WD_PRE);

  always_ff @(posedge clk_tx or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_nxt = BUSY;
      BUSY:    if (snt)   w_state_nxt = GAP;
      GAP:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_tx or posedge reset) begin
    if (reset) begin
      r_sdata <= '0;
      r_grant <= '0;
      r_ptr   <= '0;
      r_done  <= '0;
      r_cnt   <= '0;
    end else begin
      r_done <= '0;
      if (w_fire) begin
        r_sdata <= src_data[w_sel*DATA_W +: DATA_W];
        r_grant <= w_sel;
      end
      if (w_done) begin
        r_done <= NUM_SRC'(1) << r_grant;
        r_ptr  <= (r_grant == SEL_W'(NUM_SRC - 1)) ? '0 : r_grant + SEL_W'(1);
        r_cnt  <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Counter saturates, so the flag sets once per stall and err_clr can then clear it.
  always_ff @(posedge clk_tx or posedge reset) begin
    if (reset) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else begin
      if (WD_EN && (r_state == BUSY) && !snt) begin
        if (r_wd != WD_MAX) r_wd <= r_wd + WD_W'(1);
      end else begin
        r_wd <= '0;
      end
      if (w_wd_set)     r_err <= 1'b1;
      else if (err_clr) r_err <= 1'b0;
    end
  end

  assign vi          = (r_state == BUSY);
  assign busy        = (r_state != IDLE);
  assign sdata       = r_sdata;
  assign grant_id    = r_grant;
  assign src_done    = r_done;
  assign word_cnt    = r_cnt;
  assign timeout_err = r_err;

endmodule

// File: tb/tb_tx_sched.sv
// Directed bench for tx_sched (4 sources, 8-bit data, TIMEOUT=8, 4-bit counter).
module tb_tx_sched;

  localparam int NUM_SRC = 4;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 4;

  logic                       clk_tx = 1'b0;
  logic                       reset;
  logic [NUM_SRC-1:0]         src_valid;
  logic [NUM_SRC*DATA_W-1:0]  src_data;
  logic [NUM_SRC-1:0]         src_done;
  logic                       vi;
  logic [DATA_W-1:0]          sdata;
  logic                       snt;
  logic [1:0]                 grant_id;
  logic                       busy;
  logic                       err_clr;
  logic                       timeout_err;
  logic [CNT_W-1:0]           word_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] t2_data [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};

  tx_sched #(
    .NUM_SRC (NUM_SRC),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk_tx      (clk_tx),
    .reset       (reset),
    .src_valid   (src_valid),
    .src_data    (src_data),
    .src_done    (src_done),
    .vi          (vi),
    .sdata       (sdata),
    .snt         (snt),
    .grant_id    (grant_id),
    .busy        (busy),
    .err_clr     (err_clr),
    .timeout_err (timeout_err),
    .word_cnt    (word_cnt)
  );

  always #5 clk_tx = ~clk_tx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_tx);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    src_valid = '0;
    src_data  = '0;
    snt       = 1'b0;
    err_clr   = 1'b0;
    repeat (3) tick;
    chk("rst_vi",   vi,          0);
    chk("rst_busy", busy,        0);
    chk("rst_done", src_done,    0);
    chk("rst_cnt",  word_cnt,    0);
    chk("rst_err",  timeout_err, 0);
    chk("rst_data", sdata,       0);
    reset = 1'b0;

    // Single source 1, snt four cycles after vi rises
    src_data  = 32'h0000_A500;
    src_valid = 4'b0010;
    tick;
    chk("t1_vi",    vi,       1);
    chk("t1_sdata", sdata,    8'hA5);
    chk("t1_grant", grant_id, 1);
    chk("t1_busy",  busy,     1);
    repeat (3) tick;
    chk("t1_vi_hold", vi, 1);
    snt = 1'b1;
    tick;
    snt = 1'b0;
    src_valid = '0;
    chk("t1_gap_vi",   vi,       0);
    chk("t1_done",     src_done, 4'b0010);
    chk("t1_cnt",      word_cnt, 1);
    chk("t1_gap_busy", busy,     1);
    tick;
    chk("t1_idle_busy", busy,     0);
    chk("t1_idle_done", src_done, 0);

    // Async reset mid-BUSY; arbitration must restart at source 0
    src_data[31:24] = 8'h3C;
    src_valid = 4'b1000;
    tick;
    chk("t5_grant", grant_id, 3);
    tick;
    #3;
    reset = 1'b1;
    #1;
    chk("t5_vi",   vi,       0);
    chk("t5_busy", busy,     0);
    chk("t5_done", src_done, 0);
    chk("t5_cnt",  word_cnt, 0);
    src_valid = '0;
    tick;
    tick;
    reset = 1'b0;

    // All four valid, snt returned immediately
    src_data  = {t2_data[3], t2_data[2], t2_data[1], t2_data[0]};
    src_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      tick;
      chk("t2_vi",    vi,       1);
      chk("t2_grant", grant_id, k % 4);
      chk("t2_sdata", sdata,    t2_data[k%4]);
      snt = 1'b1;
      tick;
      snt = 1'b0;
      chk("t2_gap_vi", vi,       0);
      chk("t2_done",   src_done, 32'(1) << (k % 4));
      if (k == 5) src_valid = '0;
      tick;
      chk("t2_idle_vi",   vi,   0);
      chk("t2_idle_busy", busy, 0);
    end
    chk("t2_cnt", word_cnt, 6);

    // Stray snt in IDLE, then source 2 changes data while granted
    snt = 1'b1;
    tick;
    snt = 1'b0;
    chk("t3_stray_done", src_done, 0);
    chk("t3_stray_cnt",  word_cnt, 6);
    chk("t3_stray_busy", busy,     0);
    src_data[23:16] = 8'h5C;
    src_valid = 4'b0100;
    tick;
    chk("t3_grant", grant_id, 2);
    chk("t3_sdata", sdata,    8'h5C);
    src_data[23:16] = 8'hFF;
    tick;
    chk("t3_sdata_hold", sdata, 8'h5C);
    snt = 1'b1;
    tick;
    snt = 1'b0;
    src_valid = '0;
    chk("t3_done", src_done, 4'b0100);
    chk("t3_cnt",  word_cnt, 7);
    tick;

    // Watchdog: timeout after 8 BUSY cycles, clear, late snt
    src_data[7:0] = 8'h77;
    src_valid = 4'b0001;
    tick;
    chk("t4_vi",    vi,          1);
    chk("t4_grant", grant_id,    0);
    chk("t4_err0",  timeout_err, 0);
    repeat (7) tick;
    chk("t4_err_pre", timeout_err, 0);
    tick;
    chk("t4_err_set", timeout_err, 1);
    chk("t4_vi_stay", vi,          1);
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    chk("t4_err_clr", timeout_err, 0);
    chk("t4_vi_wait", vi,          1);
    snt = 1'b1;
    tick;
    snt = 1'b0;
    src_data[7:0] = 8'h78;
    chk("t4_done", src_done, 4'b0001);
    chk("t4_gap",  vi,       0);
    chk("t4_cnt",  word_cnt, 8);
    tick;
    tick;
    chk("t4b_vi",    vi,    1);
    chk("t4b_sdata", sdata, 8'h78);
    repeat (7) tick;
    chk("t4b_err_pre", timeout_err, 0);
    err_clr = 1'b1;
    tick;
    chk("t4b_set_wins", timeout_err, 1);
    tick;
    err_clr = 1'b0;
    chk("t4b_err_clr", timeout_err, 0);
    snt = 1'b1;
    tick;
    snt = 1'b0;
    src_valid = '0;
    chk("t4b_done", src_done, 4'b0001);
    chk("t4b_cnt",  word_cnt, 9);
    tick;

    // Counter wrap: 8 more transfers make 17 since reset
    src_valid = 4'b1000;
    for (int k = 0; k < 8; k++) begin
      tick;
      chk("t6_grant", grant_id, 3);
      snt = 1'b1;
      tick;
      snt = 1'b0;
      if (k == 7) src_valid = '0;
      chk("t6_cnt", word_cnt, (10 + k) % 16);
      tick;
    end
    chk("t6_wrap", word_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
